// File: rtl/seed_current_interlock_if.sv
// Bundle between adc_control, the host and the laser pins.
// Inputs are driven by the master, status comes back from the slave.
`timescale 1ns/1ps
interface seed_current_interlock_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16
);
    logic                     sample_valid;
    logic [NUM_CH*DATA_W-1:0] sample_data;
    logic [NUM_CH*DATA_W-1:0] limit_data;
    logic                     limit_update;
    logic                     enable_req;
    logic                     fault_clear;
    logic                     laser_enable;
    logic                     shutdown_n;
    logic [NUM_CH-1:0]        fault_flags;
    logic                     wdog_fault;
    logic [1:0]               state;
    logic [7:0]               trip_count;

    modport master (
        output sample_valid, sample_data, limit_data,
        output limit_update, enable_req, fault_clear,
        input  laser_enable, shutdown_n, fault_flags,
        input  wdog_fault, state, trip_count
    );

    modport slave (
        input  sample_valid, sample_data, limit_data,
        input  limit_update, enable_req, fault_clear,
        output laser_enable, shutdown_n, fault_flags,
        output wdog_fault, state, trip_count
    );
endinterface

// File: rtl/seed_current_interlock.sv
// N-channel over-current interlock: debounced limit trips, sample
// watchdog, sticky faults and an arming FSM that owns laser enable.
`timescale 1ns/1ps
module seed_current_interlock #(
    parameter int NUM_CH      = 2,
    parameter int DATA_W      = 16,
    parameter int DEBOUNCE    = 3,
    parameter int ARM_CYCLES  = 1000,
    parameter int WDOG_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    seed_current_interlock_if.slave bus
);
    localparam int CW = 4;
    localparam int AW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE);
    localparam logic [CW-1:0] DB_TRIP  = CW'(DEBOUNCE - 1);
    localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYCLES - 1);
    localparam logic [WW-1:0] WD_MAX   = WW'(WDOG_CYCLES);
    localparam logic [WW-1:0] WD_TRIP  = WW'(WDOG_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ARMING = 2'b01,
        S_ACTIVE = 2'b10,
        S_FAULT  = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_arm_cnt;
    logic [AW-1:0]     w_arm_nxt;
    logic [AW-1:0]     w_arm_inc;
    logic [WW-1:0]     r_wdog_cnt;
    logic [DATA_W-1:0] r_limit [NUM_CH];
    logic [CW-1:0]     r_cnt [NUM_CH];
    logic [NUM_CH-1:0] r_flags;
    logic              r_wdog_fault;
    logic [7:0]        r_trip_count;
    logic              r_laser_en;
    logic              r_shutdown_n;
    logic [NUM_CH-1:0] w_over;
    logic [NUM_CH-1:0] w_cur_over;
    logic [NUM_CH-1:0] w_trip;
    logic              w_clear_ok;
    logic              w_wdog_trip;
    logic              w_any_fault;

    // Limit compare per channel; "currently over" falls back to the last sample.
    always_comb begin
        w_over     = '0;
        w_cur_over = '0;
        w_trip     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_over[k]     = bus.sample_data[k*DATA_W +: DATA_W] > r_limit[k];
            w_cur_over[k] = bus.sample_valid ? w_over[k] : (r_cnt[k] != '0);
            w_trip[k]     = bus.sample_valid & w_over[k] & (r_cnt[k] >= DB_TRIP);
        end
    end

    assign w_clear_ok  = bus.fault_clear & ~|w_cur_over;
    assign w_wdog_trip = (r_state != S_IDLE) & ~bus.sample_valid
                       & (r_wdog_cnt >= WD_TRIP);
    assign w_any_fault = |r_flags | r_wdog_fault;
    assign w_arm_inc   = r_arm_cnt + 1'b1;

    // Limit registers and saturating debounce counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_limit[k] <= '1;
                r_cnt[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.limit_update)
                    r_limit[k] <= bus.limit_data[k*DATA_W +: DATA_W];
                if (bus.sample_valid) begin
                    if (!w_over[k])
                        r_cnt[k] <= '0;
                    else if (r_cnt[k] != DB_MAX)
                        r_cnt[k] <= r_cnt[k] + 1'b1;
                end else if (w_clear_ok) begin
                    r_cnt[k] <= '0;
                end
            end
        end
    end

    // Sample watchdog: idle-held, cleared by every strobe, saturating.
    always_ff @(posedge clk) begin
        if (rst)
            r_wdog_cnt <= '0;
        else if (r_state == S_IDLE || bus.sample_valid)
            r_wdog_cnt <= '0;
        else if (r_wdog_cnt != WD_MAX)
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
    end

    // Sticky fault latches; a new trip overrides a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags      <= '0;
            r_wdog_fault <= 1'b0;
        end else begin
            r_flags      <= (w_clear_ok ? '0 : r_flags) | w_trip;
            r_wdog_fault <= (w_clear_ok ? 1'b0 : r_wdog_fault) | w_wdog_trip;
        end
    end

    // Arming FSM next state; faults take priority over enable drop.
    always_comb begin
        w_state_nxt = r_state;
        w_arm_nxt   = r_arm_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_any_fault) begin
                    w_state_nxt = S_FAULT;
                end else if (bus.enable_req) begin
                    w_state_nxt = S_ARMING;
                    w_arm_nxt   = '0;
                end
            end
            S_ARMING: begin
                if (w_any_fault) begin
                    w_state_nxt = S_FAULT;
                end else if (!bus.enable_req) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_arm_nxt = w_arm_inc;
                    if (w_arm_inc >= ARM_LAST)
                        w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_any_fault)
                    w_state_nxt = S_FAULT;
                else if (!bus.enable_req)
                    w_state_nxt = S_IDLE;
            end
            S_FAULT: begin
                if (w_clear_ok && !w_wdog_trip)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register, trip counter and registered pin drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_arm_cnt    <= '0;
            r_trip_count <= '0;
            r_laser_en   <= 1'b0;
            r_shutdown_n <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_arm_cnt <= w_arm_nxt;
            if (w_state_nxt == S_FAULT && r_state != S_FAULT
                && r_trip_count != 8'hFF)
                r_trip_count <= r_trip_count + 8'd1;
            r_laser_en   <= (r_state == S_ACTIVE);
            r_shutdown_n <= (r_state != S_FAULT);
        end
    end

    assign bus.laser_enable = r_laser_en;
    assign bus.shutdown_n   = r_shutdown_n;
    assign bus.fault_flags  = r_flags;
    assign bus.wdog_fault   = r_wdog_fault;
    assign bus.state        = r_state;
    assign bus.trip_count   = r_trip_count;
endmodule
